// File: rtl/demux_rr_scheduler.sv
// Frame sequencer for a 1-to-8 demux: takes serial bits over valid/ready and
// hands one bit to each enabled channel in ascending order.
module demux_rr_scheduler #(
   parameter int NCH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [NCH-1:0]          ch_mask,
   input  logic                    abort,
   input  logic                    in_valid,
   input  logic                    in_data,
   output logic                    in_ready,
   output logic [$clog2(NCH)-1:0]  dmx_sel,
   output logic                    dmx_en,
   output logic                    dmx_in,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    err_mask
);

   localparam int SW = $clog2(NCH);

   typedef enum logic [1:0] {IDLE, SEEK, XFER, DONE} state_t;

   state_t          state, state_nxt;
   logic [NCH-1:0]  pending, pending_nxt;
   logic [SW-1:0]   low_idx;
   logic            hs;

   // Handshake: a sample moves when in_valid and in_ready are both high at a
   // rising edge; in_ready is high only in XFER and is dropped by abort.
   assign in_ready = (state == XFER) && !abort;
   assign busy     = (state != IDLE);
   assign hs       = in_valid && in_ready;

   // Scanning downward leaves the lowest set bit as the winner.
   always_comb begin
      low_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (pending[i]) low_idx = SW'(i);
      end
   end

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      case (state)
         IDLE: begin
            if (start && (ch_mask != '0)) begin
               pending_nxt = ch_mask;
               state_nxt   = SEEK;
            end
         end
         SEEK: state_nxt = XFER;
         XFER: begin
            if (hs) begin
               pending_nxt[dmx_sel] = 1'b0;
               state_nxt = (pending_nxt != '0) ? SEEK : DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort && (state != IDLE)) begin
         state_nxt   = IDLE;
         pending_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
      end
   end

   // dmx_sel only moves when leaving SEEK, so it is stable across each pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmx_sel    <= '0;
         dmx_en     <= 1'b0;
         dmx_in     <= 1'b0;
         frame_done <= 1'b0;
         err_mask   <= 1'b0;
      end else begin
         if ((state == SEEK) && !abort) dmx_sel <= low_idx;
         dmx_en     <= hs;
         dmx_in     <= hs && in_data;
         frame_done <= (state == XFER) && (state_nxt == DONE);
         err_mask   <= (state == IDLE) && start && (ch_mask == '0);
      end
   end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Bench for demux_rr_scheduler: directed scenarios plus random frames, checked
// against a transfer list and a cycle budget derived from the frame rules.
module tb_demux_rr_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] ch_mask;
   logic       abort;
   logic       in_valid;
   logic       in_data;
   logic       in_ready;
   logic [2:0] dmx_sel;
   logic       dmx_en;
   logic       dmx_in;
   logic       busy;
   logic       frame_done;
   logic       err_mask;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_busy = 0;
   logic [2:0] prev_sel = 3'd0;

   logic [3:0] exp_q[$];
   logic [3:0] obs_q[$];
   int         done_q[$];

   always #5 clk = ~clk;

   demux_rr_scheduler #(.NCH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .dmx_sel(dmx_sel), .dmx_en(dmx_en), .dmx_in(dmx_in), .busy(busy),
      .frame_done(frame_done), .err_mask(err_mask)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Per-cycle invariants plus recording of pulses for the end-of-frame checks.
   task automatic observe();
      if (dmx_en) chk("sel_stable", {29'd0, dmx_sel}, {29'd0, prev_sel});
      else        chk("din_zero", {31'd0, dmx_in}, 32'd0);
      if (dmx_en)     obs_q.push_back({dmx_sel, dmx_in});
      if (frame_done) done_q.push_back(cyc);
      if (busy)       last_busy = cyc;
      prev_sel = dmx_sel;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      observe();
   endtask

   // stall >= 0: fixed idle cycles before each sample; stall < 0: random 0..3.
   task automatic do_frame(input logic [7:0] mask, input logic [7:0] bits, input int stall,
                           input int abort_j, input logic late, input logic [7:0] late_mask);
      int ch[$];
      int s, n, stall_tot, st, w, done_at;
      logic [2:0] c3;
      bit aborted;
      exp_q.delete(); obs_q.delete(); done_q.delete();
      for (int c = 0; c < 8; c++) if (mask[c]) ch.push_back(c);
      start = 1'b1; ch_mask = mask;
      tick();
      s = cyc;
      start = 1'b0; ch_mask = 8'($urandom);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      n = 0; stall_tot = 0; aborted = 1'b0;
      for (int j = 0; j < ch.size(); j++) begin
         w = 0;
         while (!in_ready && w < 8) begin tick(); w++; end
         chk("reach_xfer", {31'd0, in_ready}, 32'd1);
         if (!in_ready) break;
         if (late && j == 1) begin start = 1'b1; ch_mask = late_mask; end
         st = (stall >= 0) ? stall : int'($urandom_range(0, 3));
         repeat (st) begin
            tick();
            chk("ready_in_stall", {31'd0, in_ready}, 32'd1);
         end
         stall_tot += st;
         c3 = 3'(ch[j]);
         if (j == abort_j) begin
            abort = 1'b1; in_valid = 1'b1; in_data = bits[c3];
            #1;
            chk("ready_abort", {31'd0, in_ready}, 32'd0);
            tick();
            abort = 1'b0; in_valid = 1'b0; in_data = 1'b0;
            chk("idle_after_abort", {31'd0, busy}, 32'd0);
            aborted = 1'b1;
            break;
         end
         exp_q.push_back({c3, bits[c3]});
         in_valid = 1'b1; in_data = bits[c3];
         tick();
         in_valid = 1'b0; in_data = 1'b0;
         n++;
      end
      start = 1'b0;
      repeat (5) tick();
      chk("busy_idle_end", {31'd0, busy}, 32'd0);
      if (aborted) begin
         chk("no_done_abort", done_q.size(), 32'd0);
      end else begin
         chk("done_count", done_q.size(), 32'd1);
         done_at = (done_q.size() > 0) ? done_q[0] : -1;
         chk("done_cycle", done_at - s, 2 * n + stall_tot);
         chk("busy_fall", last_busy - s, 2 * n + stall_tot);
      end
      chk("xfer_count", obs_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
         chk("xfer_item", {28'd0, obs_q[k]}, {28'd0, exp_q[k]});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ch_mask = 8'd0; abort = 1'b0;
      in_valid = 1'b0; in_data = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_sel", {29'd0, dmx_sel}, 32'd0);
      chk("rst_en", {31'd0, dmx_en}, 32'd0);
      chk("rst_done", {31'd0, frame_done}, 32'd0);
      chk("rst_err", {31'd0, err_mask}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Reset during the third XFER of a full frame.
      done_q.delete();
      start = 1'b1; ch_mask = 8'hFF;
      tick();
      start = 1'b0;
      for (int j = 0; j < 3; j++) begin
         int w;
         w = 0;
         while (!in_ready && w < 8) begin tick(); w++; end
         chk("rst_reach_xfer", {31'd0, in_ready}, 32'd1);
         if (j < 2) begin
            in_valid = 1'b1; in_data = 1'b1;
            tick();
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_ready", {31'd0, in_ready}, 32'd0);
      chk("midrst_sel", {29'd0, dmx_sel}, 32'd0);
      chk("midrst_en", {31'd0, dmx_en}, 32'd0);
      chk("midrst_din", {31'd0, dmx_in}, 32'd0);
      chk("midrst_done", {31'd0, frame_done}, 32'd0);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("postrst_busy", {31'd0, busy}, 32'd0);
      chk("postrst_no_done", done_q.size(), 32'd0);

      // Full frame, continuous valid, bits 1,0,1,1,0,0,1,0 on channels 0..7.
      do_frame(8'hFF, 8'b0100_1101, 0, -1, 1'b0, 8'h00);
      // Sparse mask with three idle cycles before every sample.
      do_frame(8'b1010_0100, 8'hA5, 3, -1, 1'b0, 8'h00);

      // Empty-mask start flags an error and stays idle.
      start = 1'b1; ch_mask = 8'h00;
      tick();
      start = 1'b0;
      chk("err_pulse", {31'd0, err_mask}, 32'd1);
      chk("err_not_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("err_single", {31'd0, err_mask}, 32'd0);
      chk("err_still_idle", {31'd0, busy}, 32'd0);

      // Start with another mask while busy must not disturb the sequence.
      do_frame(8'h0F, 8'h0A, 1, -1, 1'b1, 8'hF0);
      // Abort while serving channel 3, then a fresh frame restarts at channel 0.
      do_frame(8'hFF, 8'hFF, 0, 3, 1'b0, 8'h00);
      do_frame(8'hFF, 8'h3C, 0, -1, 1'b0, 8'h00);

      for (int r = 0; r < 15; r++)
         do_frame(8'($urandom_range(1, 255)), 8'($urandom), -1, -1, 1'b0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
